// File: rtl/sat_pkg.sv
// Shared types for the clause evaluation datapath.
//   lit_val_t     literal value decoded from the assignment lookup
//   clause_res_t  per-clause and per-formula result encoding (matches the result port)
//   eval_state_t  engine control states
package sat_pkg;

    typedef enum logic [1:0] {
        LitFalse   = 2'b00,
        LitTrue    = 2'b01,
        LitUnknown = 2'b10
    } lit_val_t;

    typedef enum logic [1:0] {
        ResUnsat   = 2'b00,
        ResSat     = 2'b01,
        ResUnknown = 2'b10
    } clause_res_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } eval_state_t;

    // UNSAT dominates UNKNOWN, which dominates SAT.
    function automatic clause_res_t fold_result(input logic unsat, input logic unknown);
        if (unsat) begin
            return ResUnsat;
        end else if (unknown) begin
            return ResUnknown;
        end
        return ResSat;
    endfunction

endpackage

// File: rtl/clause_lane_eval.sv
// Combinational evaluation of one clause of TERMS_PER_CLAUSE literals.
// Ports:
//   lits     in   packed literals, term t at [t*VALUE_WIDTH +: VALUE_WIDTH]
//   res      out  clause_res_t encoding: SAT if any TRUE, UNSAT if all FALSE, else UNKNOWN
//   is_unit  out  exactly one UNKNOWN literal and every other literal FALSE
module clause_lane_eval
    import sat_pkg::*;
#(
    parameter int unsigned TERMS_PER_CLAUSE = 3,
    parameter int unsigned VALUE_WIDTH      = 2
) (
    input  logic [TERMS_PER_CLAUSE*VALUE_WIDTH-1:0] lits,
    output logic [1:0]                              res,
    output logic                                    is_unit
);

    logic     any_true;
    logic     unk_one;   // at least one UNKNOWN
    logic     unk_many;  // at least two UNKNOWN
    lit_val_t lit;

    always_comb begin
        any_true = 1'b0;
        unk_one  = 1'b0;
        unk_many = 1'b0;
        lit      = LitFalse;
        for (int t = 0; t < TERMS_PER_CLAUSE; t++) begin
            // Both 10 and 11 decode as UNKNOWN.
            if (lits[t*VALUE_WIDTH +: VALUE_WIDTH] == '0) begin
                lit = LitFalse;
            end else if (lits[t*VALUE_WIDTH +: VALUE_WIDTH] == VALUE_WIDTH'(1)) begin
                lit = LitTrue;
            end else begin
                lit = LitUnknown;
            end
            case (lit)
                LitTrue:    any_true = 1'b1;
                LitUnknown: begin
                    unk_many = unk_many | unk_one;
                    unk_one  = 1'b1;
                end
                default: ;
            endcase
        end
        res     = fold_result(!any_true && !unk_one, !any_true && unk_one);
        is_unit = !any_true && unk_one && !unk_many;
    end

endmodule

// File: rtl/clause_eval_engine.sv
// Streaming k-SAT formula evaluator. Consumes beats of LANES clauses, folds the per-clause
// results into a formula result and collects DPLL hints.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a new evaluation (honoured in IDLE only)
//   in_valid/in_ready        beat handshake; in_values, in_mask, in_last qualify the beat
//   out_valid/out_ready      result handshake; outputs held while out_valid && !out_ready
//   result                   00 UNSAT, 01 SAT, 10 UNKNOWN
//   conflict_idx             first all-FALSE clause
//   unknown_count            clauses with no TRUE and at least one UNKNOWN literal
//   unit_count, unit_idx     number of unit clauses and index of the first one
//   overflow_err             more than NUM_CLAUSES masked-in clauses seen since start
//   busy                     engine not idle
module clause_eval_engine
    import sat_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES      = 64,
    parameter int unsigned LANES            = 8,
    parameter int unsigned TERMS_PER_CLAUSE = 3,
    parameter int unsigned VALUE_WIDTH      = 2,
    localparam int unsigned IDX_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
    localparam int unsigned CNT_W = $clog2(NUM_CLAUSES + 1),
    localparam int unsigned LANE_W = TERMS_PER_CLAUSE * VALUE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_values,
    input  logic [LANES-1:0]        in_mask,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              result,
    output logic [IDX_W-1:0]        conflict_idx,
    output logic [CNT_W-1:0]        unknown_count,
    output logic [CNT_W-1:0]        unit_count,
    output logic [IDX_W-1:0]        unit_idx,
    output logic                    overflow_err,
    output logic                    busy
);

    eval_state_t state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;   // masked-in clauses accepted, saturates at NUM_CLAUSES
    logic             unsat_q, unsat_d;
    logic             unit_seen_q, unit_seen_d;
    logic [IDX_W-1:0] conflict_d, unit_idx_d;
    logic [CNT_W-1:0] unknown_d, unit_d;
    logic             ovf_d;

    logic [1:0] lane_res  [LANES];
    logic       lane_unit [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        clause_lane_eval #(
            .TERMS_PER_CLAUSE (TERMS_PER_CLAUSE),
            .VALUE_WIDTH      (VALUE_WIDTH)
        ) u_lane (
            .lits    (in_values[l*LANE_W +: LANE_W]),
            .res     (lane_res[l]),
            .is_unit (lane_unit[l])
        );
    end

    // Walk lanes in ascending order so the running count gives each clause its index and the
    // first-hit captures naturally prefer the lowest lane within a beat.
    always_comb begin
        cnt_d       = cnt_q;
        unsat_d     = unsat_q;
        unit_seen_d = unit_seen_q;
        conflict_d  = conflict_idx;
        unit_idx_d  = unit_idx;
        unknown_d   = unknown_count;
        unit_d      = unit_count;
        ovf_d       = overflow_err;
        for (int l = 0; l < LANES; l++) begin
            if (in_mask[l]) begin
                if (cnt_d == CNT_W'(NUM_CLAUSES)) begin
                    ovf_d = 1'b1;
                end else begin
                    if (lane_res[l] == ResUnsat && !unsat_d) begin
                        unsat_d    = 1'b1;
                        conflict_d = IDX_W'(cnt_d);
                    end
                    if (lane_res[l] == ResUnknown) begin
                        unknown_d = unknown_d + CNT_W'(1);
                    end
                    if (lane_unit[l]) begin
                        if (!unit_seen_d) begin
                            unit_idx_d = IDX_W'(cnt_d);
                        end
                        unit_seen_d = 1'b1;
                        unit_d      = unit_d + CNT_W'(1);
                    end
                    cnt_d = cnt_d + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            unsat_q       <= 1'b0;
            unit_seen_q   <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            result        <= 2'b00;
            conflict_idx  <= '0;
            unknown_count <= '0;
            unit_count    <= '0;
            unit_idx      <= '0;
            overflow_err  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q       <= StRun;
                        in_ready      <= 1'b1;
                        busy          <= 1'b1;
                        cnt_q         <= '0;
                        unsat_q       <= 1'b0;
                        unit_seen_q   <= 1'b0;
                        result        <= 2'b00;
                        conflict_idx  <= '0;
                        unknown_count <= '0;
                        unit_count    <= '0;
                        unit_idx      <= '0;
                        overflow_err  <= 1'b0;
                    end
                end
                StRun: begin
                    if (in_valid) begin
                        cnt_q         <= cnt_d;
                        unsat_q       <= unsat_d;
                        unit_seen_q   <= unit_seen_d;
                        conflict_idx  <= conflict_d;
                        unknown_count <= unknown_d;
                        unit_count    <= unit_d;
                        unit_idx      <= unit_idx_d;
                        overflow_err  <= ovf_d;
                        if (in_last) begin
                            // Overflowed clauses are unevaluated, so they can only degrade to UNKNOWN.
                            result    <= fold_result(unsat_d, (unknown_d != '0) || ovf_d);
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state_q   <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clause_eval_engine.sv
module tb_clause_eval_engine;

    localparam logic [1:0] F  = 2'b00;
    localparam logic [1:0] T  = 2'b01;
    localparam logic [1:0] U  = 2'b10;
    localparam logic [1:0] U3 = 2'b11;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, out_ready;
    logic [23:0] in_values;
    logic [3:0]  in_mask;

    // dut_a: NUM_CLAUSES=64; dut_b: NUM_CLAUSES=8 for overflow. Both see the same stimulus.
    logic       in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [1:0] result_a;
    logic [5:0] cidx_a, uidx_a;
    logic [6:0] unk_a, unit_a;
    logic       in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [1:0] result_b;
    logic [2:0] cidx_b, uidx_b;
    logic [3:0] unk_b, unit_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clause_eval_engine #(
        .NUM_CLAUSES(64), .LANES(4), .TERMS_PER_CLAUSE(3), .VALUE_WIDTH(2)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_values(in_values), .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .result(result_a), .conflict_idx(cidx_a), .unknown_count(unk_a),
        .unit_count(unit_a), .unit_idx(uidx_a), .overflow_err(ovf_a), .busy(busy_a)
    );

    clause_eval_engine #(
        .NUM_CLAUSES(8), .LANES(4), .TERMS_PER_CLAUSE(3), .VALUE_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_values(in_values), .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .result(result_b), .conflict_idx(cidx_b), .unknown_count(unk_b),
        .unit_count(unit_b), .unit_idx(uidx_b), .overflow_err(ovf_b), .busy(busy_b)
    );

    typedef struct {
        logic [23:0] values;
        logic [3:0]  mask;
        logic [1:0]  res;
        int unsigned cidx;
        int unsigned unk;
        int unsigned unit;
        int unsigned uidx;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [5:0] ln(input logic [1:0] t0, input logic [1:0] t1,
                                      input logic [1:0] t2);
        return {t2, t1, t0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [23:0] v, input logic [3:0] m, input logic last);
        check("in_ready before beat", {31'b0, in_ready_a}, 1);
        in_valid  = 1'b1;
        in_values = v;
        in_mask   = m;
        in_last   = last;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_values = '1;  // junk while not accepted
        in_mask   = '1;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("busy after release", {31'b0, busy_a}, 0);
    endtask

    task automatic check_a(input string tag, input logic [1:0] res, input int unsigned cidx,
                           input int unsigned unk, input int unsigned unit,
                           input int unsigned uidx, input logic ovf);
        check({tag, " out_valid"}, {31'b0, out_valid_a}, 1);
        check({tag, " result"}, {30'b0, result_a}, {30'b0, res});
        check({tag, " conflict_idx"}, {26'b0, cidx_a}, cidx);
        check({tag, " unknown_count"}, {25'b0, unk_a}, unk);
        check({tag, " unit_count"}, {25'b0, unit_a}, unit);
        check({tag, " unit_idx"}, {26'b0, uidx_a}, uidx);
        check({tag, " overflow_err"}, {31'b0, ovf_a}, {31'b0, ovf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] lt, lf, lu;
        lt = ln(T, T, T);
        lf = ln(F, F, F);
        lu = ln(U, U, U);

        vecs[0] = '{{ln(T, U, F), ln(F, T, F), ln(U, U, T), ln(T, T, T)}, 4'b1111, 2'b01, 0, 0, 0, 0};
        vecs[1] = '{{ln(U, F, F), ln(T, U, U), ln(F, U, U), ln(F, F, U)}, 4'b1111, 2'b10, 0, 3, 2, 0};
        vecs[2] = '{{lf, ln(U, F, F), lf, ln(T, F, F)}, 4'b1111, 2'b00, 1, 1, 1, 2};
        vecs[3] = '{{lf, lf, ln(F, F, U3), lf}, 4'b1010, 2'b00, 1, 1, 1, 0};
        vecs[4] = '{{lf, lf, lf, lf}, 4'b0000, 2'b01, 0, 0, 0, 0};
        vecs[5] = '{{lf, ln(U, U, F), lf, lf}, 4'b0100, 2'b10, 0, 1, 0, 0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_values = '0; in_mask = '0;
        #1;
        check("reset in_ready", {31'b0, in_ready_a}, 0);
        check("reset out_valid", {31'b0, out_valid_a}, 0);
        check("reset busy", {31'b0, busy_a}, 0);
        check("reset result", {30'b0, result_a}, 0);
        check("reset overflow", {31'b0, ovf_b}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-beat formulas from the table.
        for (int i = 0; i < 6; i++) begin
            do_start();
            send_beat(vecs[i].values, vecs[i].mask, 1'b1);
            check_a($sformatf("vec%0d", i), vecs[i].res, vecs[i].cidx, vecs[i].unk,
                    vecs[i].unit, vecs[i].uidx, 1'b0);
            check($sformatf("vec%0d dut_b result", i), {30'b0, result_b}, {30'b0, vecs[i].res});
            release_result();
        end

        // Three beats: conflict at index 6, a later conflict at index 8 must not overwrite it.
        do_start();
        send_beat({lt, lt, lt, lt}, 4'b1111, 1'b0);
        send_beat({lt, lf, lt, lt}, 4'b1111, 1'b0);
        check("multi mid out_valid", {31'b0, out_valid_a}, 0);
        check("multi mid busy", {31'b0, busy_a}, 1);
        send_beat({lt, lt, lt, lf}, 4'b1111, 1'b1);
        check_a("multi", 2'b00, 6, 0, 0, 0, 1'b0);
        check("multi b result", {30'b0, result_b}, 0);
        check("multi b conflict_idx", {29'b0, cidx_b}, 6);
        check("multi b overflow", {31'b0, ovf_b}, 1);
        release_result();

        // Overflow on dut_b: 12 clauses into an 8-clause engine forces UNKNOWN.
        do_start();
        send_beat({lt, lt, lt, lu}, 4'b1111, 1'b0);
        send_beat({lt, lt, lt, lt}, 4'b1111, 1'b0);
        send_beat({lt, lt, lt, lu}, 4'b1111, 1'b1);
        check_a("ovf a", 2'b10, 0, 2, 0, 0, 1'b0);
        check("ovf b out_valid", {31'b0, out_valid_b}, 1);
        check("ovf b result", {30'b0, result_b}, 2);
        check("ovf b unknown_count", {28'b0, unk_b}, 1);
        check("ovf b overflow", {31'b0, ovf_b}, 1);
        release_result();
        do_start();
        check("ovf b cleared by start", {31'b0, ovf_b}, 0);
        send_beat({lt, lt, lt, lt}, 4'b1111, 1'b1);
        check("ovf b next result", {30'b0, result_b}, 1);
        release_result();

        // Hold the result with out_ready low; start must be ignored.
        do_start();
        send_beat(vecs[1].values, 4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            @(negedge clk);
            check($sformatf("hold%0d out_valid", c), {31'b0, out_valid_a}, 1);
            check($sformatf("hold%0d result", c), {30'b0, result_a}, 2);
            check($sformatf("hold%0d unknown_count", c), {25'b0, unk_a}, 3);
            check($sformatf("hold%0d in_ready", c), {31'b0, in_ready_a}, 0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold released out_valid", {31'b0, out_valid_a}, 0);
        check("hold released busy", {31'b0, busy_a}, 0);
        do_start();
        check("back-to-back busy", {31'b0, busy_a}, 1);
        send_beat({lt, lt, lt, lt}, 4'b1111, 1'b1);
        check_a("back-to-back", 2'b01, 0, 0, 0, 0, 1'b0);
        release_result();

        // Asynchronous reset in the middle of a run.
        do_start();
        send_beat({lt, ln(U, U, F), lf, lt}, 4'b1111, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst in_ready", {31'b0, in_ready_a}, 0);
        check("midrst busy", {31'b0, busy_a}, 0);
        check("midrst out_valid", {31'b0, out_valid_a}, 0);
        check("midrst result", {30'b0, result_a}, 0);
        check("midrst conflict_idx", {26'b0, cidx_a}, 0);
        check("midrst unknown_count", {25'b0, unk_a}, 0);
        check("midrst unit_count", {25'b0, unit_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        send_beat({lt, lt, lt, lt}, 4'b1111, 1'b1);
        check_a("after reset", 2'b01, 0, 0, 0, 0, 1'b0);
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
